// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_ctrl_pkg
//  Description : Shared state encoding and pushbutton index map for counter_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================

package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        STEP  = 2'd2
    } ctrl_state_t;

    localparam int NUM_KEYS = 4;

    localparam int KEY_CLR  = 0;
    localparam int KEY_RUN  = 1;
    localparam int KEY_STEP = 2;
    localparam int KEY_DIR  = 3;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Two-flop synchronizer, debounce filter and press pulse for
//                one active-low pushbutton.
//  Revision    : 1.0 - initial release
// ============================================================================

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK,
    input  logic RESETn,
    input  logic key_i,
    output logic press_o
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          level_prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt_d = cnt_q + CW'(1);

    always_ff @(posedge CLOCK) begin
        if (!RESETn) begin
            meta_q       <= 1'b1;
            sync_q       <= 1'b1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            meta_q       <= key_i;
            sync_q       <= meta_q;
            level_prev_q <= level_q;
            // Only the released-to-pressed edge of the filtered level is an event.
            press_q      <= level_prev_q & ~level_q;

            if (sync_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_d == CNT_DONE) begin
                level_q <= sync_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_ctrl
//  Description : Pushbutton front end for a downstream counter: run/pause/step
//                control, prescaled enable, clear pulse and direction level.
//  Revision    : 1.0 - initial release
// ============================================================================

module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_DIV        = 1
) (
    input  logic       CLOCK,
    input  logic       RESETn,
    input  logic [3:0] KEY,
    output logic       EN,
    output logic       CLR,
    output logic       UP,
    output logic [1:0] STATE
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [NUM_KEYS-1:0] key_press;

    generate
        for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .CLOCK   (CLOCK),
                .RESETn  (RESETn),
                .key_i   (KEY[k]),
                .press_o (key_press[k])
            );
        end
    endgenerate

    ctrl_state_t   state_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          presc_last;
    logic          en_q;
    logic          clr_q;
    logic          up_q;

    assign presc_last = (presc_q == PRESC_LAST);
    assign presc_d    = presc_last ? '0 : presc_q + PW'(1);

    // The prescaler advances on every edge whose destination state is RUN, so
    // EN never fires in the first PAUSE cycle and resumes on the held phase.
    always_ff @(posedge CLOCK) begin
        if (!RESETn) begin
            state_q <= RUN;
            presc_q <= '0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            up_q    <= 1'b1;
        end else begin
            en_q  <= 1'b0;
            clr_q <= key_press[KEY_CLR];

            if (key_press[KEY_DIR]) begin
                up_q <= ~up_q;
            end

            case (state_q)
                RUN: begin
                    if (key_press[KEY_RUN]) begin
                        state_q <= PAUSE;
                    end else begin
                        presc_q <= presc_d;
                        en_q    <= presc_last;
                    end
                end
                PAUSE: begin
                    if (key_press[KEY_RUN]) begin
                        state_q <= RUN;
                        presc_q <= presc_d;
                        en_q    <= presc_last;
                    end else if (key_press[KEY_STEP]) begin
                        state_q <= STEP;
                        en_q    <= 1'b1;
                    end
                end
                STEP: begin
                    state_q <= PAUSE;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase

            // Clear wins over any enable decided above.
            if (key_press[KEY_CLR]) begin
                presc_q <= '0;
                en_q    <= 1'b0;
            end
        end
    end

    assign EN    = en_q;
    assign CLR   = clr_q;
    assign UP    = up_q;
    assign STATE = state_q;

endmodule

`default_nettype wire
